irq_edge_ctrl: RTL and testbench

- Memory-mapped interrupt front-end between raw GPIO input pins and the CPU `irq` vector.
- Synchronises up to NUM_LINES asynchronous pin inputs and detects the configured edge or level per line.
- Latches events in a pending register and drives one masked irq bit per line into the top-level `irq` assignment.
- Replaces direct pin-to-irq wiring. Sits on the CPU memory bus with the same valid/ready slave protocol as the other peripherals; top-level select is `mem_addr[31:24] == 8'h5`.

---
 rtl/irq_edge_ctrl_pkg.sv | 23 ++
 rtl/irq_edge_ctrl_line.sv | 68 ++++++
 rtl/irq_edge_ctrl.sv | 104 ++++++++++
 tb/tb_irq_edge_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/irq_edge_ctrl_pkg.sv
// Shared register offsets and line mode encodings for the GPIO interrupt front-end.
// The firmware header mirrors these values.
package irq_edge_ctrl_pkg;

   localparam logic [4:0] IRQ_STATUS  = 5'h00;
   localparam logic [4:0] IRQ_PENDING = 5'h04;
   localparam logic [4:0] IRQ_ENABLE  = 5'h08;
   localparam logic [4:0] IRQ_MODE    = 5'h0C;
   localparam logic [4:0] IRQ_TRIGGER = 5'h10;

   typedef enum logic [1:0] {
      MODE_RISE  = 2'b00,
      MODE_FALL  = 2'b01,
      MODE_BOTH  = 2'b10,
      MODE_LEVEL = 2'b11
   } irq_mode_e;

   // Expand byte strobes into a per-bit write mask.
   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
   endfunction

endpackage

// File: rtl/irq_edge_ctrl_line.sv
// One interrupt line: pin synchroniser, edge/level detect, pending bit and masked irq flop.
// Pin-to-pending latency is SYNC_STAGES+1 cycles; irq follows one cycle later.
module irq_line
   import irq_edge_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      pin,
   input  irq_mode_e mode,
   input  logic      w1c,
   input  logic      trig,
   input  logic      en,
   output logic      sync,
   output logic      pending,
   output logic      irq
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic prev_q, prev_d;
   logic pending_q, pending_d;
   logic irq_q, irq_d;
   logic rise, fall, evt;

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], pin};
      sync      = sync_q[SYNC_STAGES-1];
      prev_d    = sync;
      rise      = sync & ~prev_q;
      fall      = ~sync & prev_q;
      evt       = 1'b0;
      pending_d = pending_q;
      case (mode)
         MODE_RISE: evt = rise;
         MODE_FALL: evt = fall;
         MODE_BOTH: evt = rise | fall;
         default:   evt = 1'b0;
      endcase
      // Level mode follows the pin; otherwise a fresh event beats a same-cycle clear.
      if (mode == MODE_LEVEL) begin
         pending_d = sync;
      end else if (evt || trig) begin
         pending_d = 1'b1;
      end else if (w1c) begin
         pending_d = 1'b0;
      end
      irq_d = pending_q & en;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= '0;
         prev_q    <= 1'b0;
         pending_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         prev_q    <= prev_d;
         pending_q <= pending_d;
         irq_q     <= irq_d;
      end
   end

   assign pending = pending_q;
   assign irq     = irq_q;

endmodule

// File: rtl/irq_edge_ctrl.sv
// Memory-mapped interrupt front-end: bus decode, ENABLE/MODE registers and read mux
// around one irq_line per input pin. Accesses acknowledge one cycle after valid.
module irq_edge_ctrl
   import irq_edge_ctrl_pkg::*;
#(
   parameter int NUM_LINES   = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid,
   output logic                 ready,
   input  logic [3:0]           wstrb,
   input  logic [31:0]          addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   input  logic [NUM_LINES-1:0] pin_in,
   output logic [NUM_LINES-1:0] irq_out
);

   logic ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic [NUM_LINES-1:0] enable_q, enable_d;
   logic [2*NUM_LINES-1:0] mode_q, mode_d;
   logic [NUM_LINES-1:0] sync_vec, pend_vec, w1c_vec, trig_vec;
   logic access, do_wr;
   logic [4:0] reg_off;
   logic [31:0] wmask, rd_mux;
   logic unused_bits;

   assign unused_bits = ^{addr, wdata, wmask};

   always_comb begin
      access   = valid & ~ready_q;
      do_wr    = access & (|wstrb);
      reg_off  = {addr[4:2], 2'b00};
      wmask    = strb_mask(wstrb);
      ready_d  = access;
      enable_d = enable_q;
      mode_d   = mode_q;
      w1c_vec  = '0;
      trig_vec = '0;
      rd_mux   = '0;
      case (reg_off)
         IRQ_STATUS:  rd_mux[NUM_LINES-1:0] = sync_vec;
         IRQ_PENDING: begin
            rd_mux[NUM_LINES-1:0] = pend_vec;
            w1c_vec = wdata[NUM_LINES-1:0] & wmask[NUM_LINES-1:0] & {NUM_LINES{do_wr}};
         end
         IRQ_ENABLE: begin
            rd_mux[NUM_LINES-1:0] = enable_q;
            if (do_wr) begin
               enable_d = (enable_q & ~wmask[NUM_LINES-1:0])
                        | (wdata[NUM_LINES-1:0] & wmask[NUM_LINES-1:0]);
            end
         end
         IRQ_MODE: begin
            rd_mux[2*NUM_LINES-1:0] = mode_q;
            if (do_wr) begin
               mode_d = (mode_q & ~wmask[2*NUM_LINES-1:0])
                      | (wdata[2*NUM_LINES-1:0] & wmask[2*NUM_LINES-1:0]);
            end
         end
         IRQ_TRIGGER: trig_vec = wdata[NUM_LINES-1:0] & wmask[NUM_LINES-1:0] & {NUM_LINES{do_wr}};
         default: ;
      endcase
      rdata_d = (access && !do_wr) ? rd_mux : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ready_q  <= 1'b0;
         rdata_q  <= '0;
         enable_q <= '0;
         mode_q   <= '0;
      end else begin
         ready_q  <= ready_d;
         rdata_q  <= rdata_d;
         enable_q <= enable_d;
         mode_q   <= mode_d;
      end
   end

   assign ready = ready_q;
   assign rdata = rdata_q;

   for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
      irq_line #(
         .SYNC_STAGES(SYNC_STAGES)
      ) u_line (
         .clk     (clk),
         .reset   (reset),
         .pin     (pin_in[i]),
         .mode    (irq_mode_e'(mode_q[2*i +: 2])),
         .w1c     (w1c_vec[i]),
         .trig    (trig_vec[i]),
         .en      (enable_q[i]),
         .sync    (sync_vec[i]),
         .pending (pend_vec[i]),
         .irq     (irq_out[i])
      );
   end

endmodule

// File: tb/tb_irq_edge_ctrl.sv
// Directed bench for irq_edge_ctrl: bus access, edge/level detection, W1C races and masking.
module tb_irq_edge_ctrl;
   import irq_edge_ctrl_pkg::*;

   localparam logic [31:0] BASE = 32'h0500_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid;
   logic        ready;
   logic [3:0]  wstrb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  pin_in;
   logic [7:0]  irq_out;

   int total = 0;
   int bad   = 0;

   irq_edge_ctrl #(
      .NUM_LINES  (8),
      .SYNC_STAGES(2)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .valid  (valid),
      .ready  (ready),
      .wstrb  (wstrb),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .pin_in (pin_in),
      .irq_out(irq_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rd);
      int n;
      @(posedge clk);
      #1;
      valid = 1'b1;
      addr  = a;
      wstrb = s;
      wdata = d;
      n     = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ready && n < 8);
      chk("ready_lat", n, 1);
      rd    = rdata;
      valid = 1'b0;
      wstrb = 4'h0;
   endtask

   task automatic wr(input logic [4:0] off, input logic [31:0] d);
      logic [31:0] dummy;
      bus(BASE | {27'h0, off}, 4'hF, d, dummy);
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] off, input logic [31:0] exp);
      logic [31:0] v;
      bus(BASE | {27'h0, off}, 4'h0, 32'h0, v);
      chk(tag, v, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] dummy;
      reset  = 1'b1;
      valid  = 1'b0;
      wstrb  = 4'h0;
      addr   = 32'h0;
      wdata  = 32'h0;
      pin_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", {31'h0, ready}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_irq", {24'h0, irq_out}, 32'h0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         rd_chk("rst_read", 5'(i * 4), 32'h0);
      end
      chk("idle_rdata", rdata, 32'h0);

      // Rising edge on line 0 with pipeline latency.
      wr(IRQ_ENABLE, 32'h01);
      pin_in[0] = 1'b1;
      cyc(3);
      chk("rise_irq_early", {24'h0, irq_out}, 32'h00);
      cyc(1);
      chk("rise_irq", {24'h0, irq_out}, 32'h01);
      rd_chk("rise_pend", IRQ_PENDING, 32'h01);
      wr(IRQ_PENDING, 32'h01);
      cyc(1);
      chk("w1c_irq", {24'h0, irq_out}, 32'h00);
      rd_chk("w1c_pend", IRQ_PENDING, 32'h00);

      // Falling-only then both-edge mode on line 2.
      wr(IRQ_MODE, 32'h10);
      pin_in[2] = 1'b1;
      cyc(5);
      rd_chk("fall_norise", IRQ_PENDING, 32'h00);
      pin_in[2] = 1'b0;
      cyc(5);
      rd_chk("fall_set", IRQ_PENDING, 32'h04);
      wr(IRQ_MODE, 32'h20);
      rd_chk("mode_keeps_pend", IRQ_PENDING, 32'h04);
      wr(IRQ_PENDING, 32'h04);
      rd_chk("both_clr", IRQ_PENDING, 32'h00);
      pin_in[2] = 1'b1;
      cyc(5);
      rd_chk("both_rise", IRQ_PENDING, 32'h04);
      wr(IRQ_PENDING, 32'h04);
      pin_in[2] = 1'b0;
      cyc(5);
      rd_chk("both_fall", IRQ_PENDING, 32'h04);
      wr(IRQ_PENDING, 32'h04);
      rd_chk("both_clr2", IRQ_PENDING, 32'h00);
      rd_chk("status1", IRQ_STATUS, 32'h01);

      // Line 1: plain W1C, then an edge landing in the same cycle as the W1C commit.
      wr(IRQ_TRIGGER, 32'h02);
      rd_chk("trig1", IRQ_PENDING, 32'h02);
      wr(IRQ_PENDING, 32'h02);
      rd_chk("w1c1", IRQ_PENDING, 32'h00);
      wr(IRQ_TRIGGER, 32'h02);
      pin_in[1] = 1'b1;
      cyc(1);
      wr(IRQ_PENDING, 32'h02);
      rd_chk("race_edge_wins", IRQ_PENDING, 32'h02);
      wr(IRQ_PENDING, 32'h02);
      rd_chk("race_clr", IRQ_PENDING, 32'h00);

      // Level-high mode on line 3.
      wr(IRQ_MODE, 32'hE0);
      wr(IRQ_ENABLE, 32'h09);
      pin_in[3] = 1'b1;
      cyc(3);
      chk("lvl_irq_early", {24'h0, irq_out}, 32'h00);
      cyc(1);
      chk("lvl_irq", {24'h0, irq_out}, 32'h08);
      rd_chk("lvl_pend", IRQ_PENDING, 32'h08);
      wr(IRQ_PENDING, 32'h08);
      rd_chk("lvl_w1c_ign", IRQ_PENDING, 32'h08);
      rd_chk("status2", IRQ_STATUS, 32'h0B);
      pin_in[3] = 1'b0;
      cyc(4);
      chk("lvl_irq_low", {24'h0, irq_out}, 32'h00);
      rd_chk("lvl_low", IRQ_PENDING, 32'h00);
      wr(IRQ_TRIGGER, 32'h08);
      rd_chk("lvl_trig_ign", IRQ_PENDING, 32'h00);

      // Software trigger with masking and byte strobes.
      wr(IRQ_ENABLE, 32'h00);
      wr(IRQ_PENDING, 32'hFF);
      wr(IRQ_TRIGGER, 32'h80);
      rd_chk("trig_pend", IRQ_PENDING, 32'h80);
      cyc(1);
      chk("trig_masked", {24'h0, irq_out}, 32'h00);
      rd_chk("trig_read0", IRQ_TRIGGER, 32'h00);
      bus(BASE | {27'h0, IRQ_ENABLE}, 4'b0001, 32'hFFFF_FF80, dummy);
      chk("en_irq_same", {24'h0, irq_out}, 32'h00);
      cyc(1);
      chk("en_irq", {24'h0, irq_out}, 32'h80);
      rd_chk("en_read", IRQ_ENABLE, 32'h80);
      bus(BASE | {27'h0, IRQ_ENABLE}, 4'b0010, 32'h0000_FF00, dummy);
      rd_chk("en_strb", IRQ_ENABLE, 32'h80);
      bus(BASE | {27'h0, IRQ_MODE}, 4'b0010, 32'h0000_5500, dummy);
      rd_chk("mode_strb", IRQ_MODE, 32'h55E0);
      rd_chk("mode_pend", IRQ_PENDING, 32'h80);
      wr(5'h18, 32'hFF);
      rd_chk("unmapped", 5'h18, 32'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
